serial_subtractor_ctrl: RTL and testbench

Bit-serial multi-bit subtraction engine built around one shared 1-bit subtract cell: a half-subtractor pair with a borrow register. The block accepts two WIDTH-bit unsigned operands on a start strobe and processes them LSB-first, one bit per clock. It returns the difference and the final borrow with a one-cycle done pulse. It is the sequencing/controller layer that lets the 1-bit subtractor datapath serve arbitrary word widths at minimal area.

---
 rtl/serial_subtractor_ctrl_if.sv | 23 ++
 rtl/serial_subtractor_ctrl.sv | 102 ++++++++++
 tb/tb_serial_subtractor_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_ctrl_if.sv
// Request/response bundle for the bit-serial subtractor: operands and start in,
// busy/done status and the registered result out.
interface serial_subtractor_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow_out
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow_out
    );
endinterface

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial WIDTH-bit subtractor: one shared 1-bit subtract cell (two half-subtractors
// plus a borrow register) walks the operands LSB-first, one bit per clock.
module serial_subtractor_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input logic                     clk,
    input logic                     rst_n,
    serial_subtractor_ctrl_if.slave bus
);
    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StShift = 2'd1;
    localparam logic [1:0] StDone  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic             br_q, br_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;

    // Shared 1-bit subtract cell.
    logic d1, b1, d_bit, b2, bnext;

    always_comb begin
        d1    = sa_q[0] ^ sb_q[0];
        b1    = ~sa_q[0] & sb_q[0];
        d_bit = d1 ^ br_q;
        b2    = ~d1 & br_q;
        bnext = b1 | b2;
    end

    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        sr_d     = sr_q;
        br_d     = br_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;

        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    sa_d    = bus.a;
                    sb_d    = bus.b;
                    sr_d    = '0;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                sr_d  = {d_bit, sr_q[WIDTH-1:1]};
                sa_d  = {1'b0, sa_q[WIDTH-1:1]};
                sb_d  = {1'b0, sb_q[WIDTH-1:1]};
                br_d  = bnext;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastBit) begin
                    diff_d   = {d_bit, sr_q[WIDTH-1:1]};
                    borrow_d = bnext;
                    state_d  = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            sa_q     <= '0;
            sb_q     <= '0;
            sr_q     <= '0;
            br_q     <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            sr_q     <= sr_d;
            br_q     <= br_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

    // Status is a pure decode of the state register, so no input reaches an output.
    assign bus.busy       = (state_q == StShift);
    assign bus.done       = (state_q == StDone);
    assign bus.diff       = diff_q;
    assign bus.borrow_out = borrow_q;
endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Directed and randomised checks of serial_subtractor_ctrl at WIDTH=8 and WIDTH=13.
module tb_serial_subtractor_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    serial_subtractor_ctrl_if #(.WIDTH(8))  bus8 ();
    serial_subtractor_ctrl_if #(.WIDTH(13)) bus13 ();

    serial_subtractor_ctrl #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    serial_subtractor_ctrl #(.WIDTH(13)) dut13 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus13)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_diff;
        logic       exp_borrow;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Protocol invariants on both instances.
    logic done8_prev = 1'b0, done13_prev = 1'b0;
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("busy_done_overlap8", 32'(bus8.busy & bus8.done), 32'd0);
            chk("done_twice8", 32'(bus8.done & done8_prev), 32'd0);
            chk("busy_done_overlap13", 32'(bus13.busy & bus13.done), 32'd0);
            chk("done_twice13", 32'(bus13.done & done13_prev), 32'd0);
        end
        done8_prev  = bus8.done;
        done13_prev = bus13.done;
    end

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] ed,
                       input logic eb, input string name);
        int lat = 1;
        int nbusy = 0;
        bit seen = 0;
        @(negedge clk);
        bus8.start = 1'b1; bus8.a = a; bus8.b = b;
        @(negedge clk);
        bus8.start = 1'b0; bus8.a = ~a; bus8.b = ~b;
        while (!seen && lat <= 30) begin
            if (bus8.done) seen = 1;
            else begin
                if (bus8.busy) nbusy++;
                @(negedge clk);
                lat++;
            end
        end
        chk({name, "_seen"}, 32'(seen), 32'd1);
        chk({name, "_latency"}, 32'(lat), 32'd9);
        chk({name, "_busy_cycles"}, 32'(nbusy), 32'd8);
        chk({name, "_diff"}, 32'(bus8.diff), 32'(ed));
        chk({name, "_borrow"}, 32'(bus8.borrow_out), 32'(eb));
    endtask

    task automatic op13(input logic [12:0] a, input logic [12:0] b);
        logic [13:0] expv = {1'b0, a} - {1'b0, b};
        int lat = 1;
        bit seen = 0;
        @(negedge clk);
        bus13.start = 1'b1; bus13.a = a; bus13.b = b;
        @(negedge clk);
        bus13.start = 1'b0; bus13.a = ~a; bus13.b = ~b;
        while (!seen && lat <= 40) begin
            if (bus13.done) seen = 1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        chk("w13_latency", 32'(lat), 32'd14);
        chk("w13_result", 32'({bus13.borrow_out, bus13.diff}), 32'(expv));
    endtask

    vec_t vecs[9];
    int   dcount;
    int   dpos[$];
    logic [7:0] ra, rb;
    logic [8:0] rexp;

    initial begin
        vecs[0] = '{8'h5A, 8'h3C, 8'h1E, 1'b0};
        vecs[1] = '{8'h00, 8'h01, 8'hFF, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 8'h00, 1'b0};
        vecs[3] = '{8'h03, 8'h05, 8'hFE, 1'b1};
        vecs[4] = '{8'h80, 8'h7F, 8'h01, 1'b0};
        vecs[5] = '{8'h00, 8'h00, 8'h00, 1'b0};
        vecs[6] = '{8'h01, 8'hFF, 8'h02, 1'b1};
        vecs[7] = '{8'hAA, 8'h55, 8'h55, 1'b0};
        vecs[8] = '{8'h7F, 8'h80, 8'hFF, 1'b1};

        rst_n = 1'b0;
        bus8.start = 1'b0;  bus8.a = '0;  bus8.b = '0;
        bus13.start = 1'b0; bus13.a = '0; bus13.b = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(bus8.busy), 32'd0);
        chk("reset_done", 32'(bus8.done), 32'd0);
        chk("reset_diff", 32'(bus8.diff), 32'd0);
        chk("reset_borrow", 32'(bus8.borrow_out), 32'd0);
        chk("reset_diff13", 32'({bus13.borrow_out, bus13.diff}), 32'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) op8(vecs[i].a, vecs[i].b, vecs[i].exp_diff, vecs[i].exp_borrow,
                              $sformatf("vec%0d", i));

        // Start re-pulsed with new operands during SHIFT and during DONE.
        @(negedge clk);
        bus8.start = 1'b1; bus8.a = 8'h10; bus8.b = 8'h01;
        dcount = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (bus8.done) begin
                dcount++;
                chk("ignore_diff", 32'(bus8.diff), 32'h0F);
                chk("ignore_borrow", 32'(bus8.borrow_out), 32'd0);
            end
            bus8.start = (i == 2) || bus8.done;
            if (bus8.start) begin bus8.a = 8'hAA; bus8.b = 8'h55; end
        end
        chk("ignore_done_count", 32'(dcount), 32'd1);

        // Reset during the 4th SHIFT cycle aborts the operation.
        @(negedge clk);
        bus8.start = 1'b1; bus8.a = 8'h12; bus8.b = 8'h34;
        dcount = 0;
        for (int i = 1; i < 20; i++) begin
            @(negedge clk);
            bus8.start = 1'b0;
            if (i == 4) rst_n = 1'b0;
            if (i == 5) begin
                chk("abort_busy", 32'(bus8.busy), 32'd0);
                chk("abort_done", 32'(bus8.done), 32'd0);
                chk("abort_diff", 32'(bus8.diff), 32'd0);
                chk("abort_borrow", 32'(bus8.borrow_out), 32'd0);
                rst_n = 1'b1;
            end
            if (bus8.done) dcount++;
        end
        chk("abort_no_done", 32'(dcount), 32'd0);
        op8(8'h80, 8'h7F, 8'h01, 1'b0, "after_abort");

        // Start held high: one completion every WIDTH+2 cycles.
        @(negedge clk);
        bus8.start = 1'b1; bus8.a = 8'hC3; bus8.b = 8'h3C;
        for (int i = 1; i <= 45; i++) begin
            @(negedge clk);
            if (bus8.done) begin
                dpos.push_back(i);
                chk("hold_diff", 32'({bus8.borrow_out, bus8.diff}), 32'h087);
            end
        end
        bus8.start = 1'b0;
        chk("hold_done_count", 32'(dpos.size()), 32'd4);
        if (dpos.size() > 0) chk("hold_first_done", 32'(dpos[0]), 32'd9);
        for (int i = 1; i < dpos.size(); i++)
            chk("hold_interval", 32'(dpos[i] - dpos[i-1]), 32'd10);
        repeat (12) @(negedge clk);

        for (int i = 0; i < 150; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rexp = {1'b0, ra} - {1'b0, rb};
            op8(ra, rb, rexp[7:0], rexp[8], "rand8");
        end
        for (int i = 0; i < 150; i++) op13(13'($urandom), 13'($urandom));
        op13(13'h0000, 13'h1FFF);
        op13(13'h1FFF, 13'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
